// File: rtl/serial_parity_pkg.sv
// Shared types and sizing helpers for the serial even-parity frame checker.
package serial_parity_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam int MAX_LEN_DEFAULT = 16;

  // Width needed to hold a data-bit count from 0 to max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/xor_gate_using_mux.sv
// Two-input XOR built from a 2:1 mux: i_b selects between i_a and its inverse.
module xor_gate_using_mux (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  assign o_y = i_b ? ~i_a : i_a;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame checker: accumulates data bits, checks a trailing even-parity bit.
// Error counter present only when SERIAL_PARITY_ERR_CNT_EN is defined.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int ERR_W   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            up_valid,
  input  logic                            up_data,
  input  logic                            up_last,
  output logic                            down_valid,
  output logic                            down_ok,
  output logic [len_width(MAX_LEN)-1:0]   down_len,
  output logic                            down_ovf,
  output logic [ERR_W-1:0]                err_count
);

  localparam int                LEN_W   = len_width(MAX_LEN);
  localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(MAX_LEN);

  state_t             r_state;
  logic               r_acc;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovf;
  logic               r_down_valid;
  logic               r_down_ok;
  logic [LEN_W-1:0]   r_down_len;
  logic               r_down_ovf;

  state_t             w_state_next;
  logic               w_acc_next;
  logic [LEN_W-1:0]   w_len_next;
  logic               w_ovf_next;
  logic               w_verdict;
  logic               w_acc_in;
  logic               w_acc_xor;
  logic [LEN_W-1:0]   w_frame_len;
  logic               w_frame_ovf;
  logic               w_ok;

  // From IDLE the accumulator is treated as zero, so one XOR serves both
  // the first data bit and the lone-parity-bit frame.
  assign w_acc_in    = (r_state == ACC) ? r_acc : 1'b0;
  assign w_frame_len = (r_state == ACC) ? r_len : '0;
  assign w_frame_ovf = (r_state == ACC) && r_ovf;
  assign w_ok        = !w_acc_xor && !w_frame_ovf;

  xor_gate_using_mux u_acc_xor (
    .i_a (w_acc_in),
    .i_b (up_data),
    .o_y (w_acc_xor)
  );

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_len_next   = r_len;
    w_ovf_next   = r_ovf;
    w_verdict    = 1'b0;
    if (up_valid) begin
      if (up_last) begin
        w_verdict    = 1'b1;
        w_state_next = IDLE;
        w_acc_next   = 1'b0;
        w_len_next   = '0;
        w_ovf_next   = 1'b0;
      end else begin
        w_acc_next = w_acc_xor;
        case (r_state)
          IDLE: begin
            w_len_next   = LEN_W'(1);
            w_ovf_next   = 1'b0;
            w_state_next = ACC;
          end
          default: begin
            if (r_len == LEN_MAX) begin
              w_ovf_next = 1'b1;
            end else begin
              w_len_next = r_len + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_acc        <= 1'b0;
      r_len        <= '0;
      r_ovf        <= 1'b0;
      r_down_valid <= 1'b0;
      r_down_ok    <= 1'b0;
      r_down_len   <= '0;
      r_down_ovf   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_acc        <= w_acc_next;
      r_len        <= w_len_next;
      r_ovf        <= w_ovf_next;
      r_down_valid <= w_verdict;
      // Verdict fields hold between pulses.
      if (w_verdict) begin
        r_down_ok  <= w_ok;
        r_down_len <= w_frame_len;
        r_down_ovf <= w_frame_ovf;
      end
    end
  end

  assign down_valid = r_down_valid;
  assign down_ok    = r_down_ok;
  assign down_len   = r_down_len;
  assign down_ovf   = r_down_ovf;

`ifdef SERIAL_PARITY_ERR_CNT_EN
  logic [ERR_W-1:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_verdict && !w_ok && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

endmodule
